pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 13 +
 rtl/pwm_capture_sync_edge.sv | 37 +++
 rtl/pwm_capture.sv | 125 ++++++++++++
 tb/tb_pwm_capture.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared PWM state encodings and default sizing
package pwm_capture_pkg;

   localparam int PWM_CNT_W   = 10;
   localparam int PWM_TIMEOUT = 1000;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// rtl/pwm_capture_sync_edge.sv - two-flop synchronizer with history flop and edge detect
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   // s3 only remembers the previous synchronized level for edge detection
   assign level = s2_q;
   assign rise  = s2_q & ~s3_q;
   assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period measurement with stuck-input detection
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W   = PWM_CNT_W,
   parameter int TIMEOUT = PWM_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             stuck_high,
   output logic             stuck_low
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   logic level, rise, fall;
   logic timeout;

   pwm_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic             valid_q, valid_d;
   logic             sh_q, sh_d;
   logic             sl_q, sl_d;

   sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (pwm_in),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      high_d  = high_q;
      per_d   = per_q;
      valid_d = 1'b0;
      sh_d    = sh_q;
      sl_d    = sl_q;

      // an edge arriving on the saturation cycle beats the timeout
      timeout = (cnt_q == TMO) && !rise && !fall;

      if (rise) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q < TMO) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (rise || fall) begin
         sh_d = 1'b0;
         sl_d = 1'b0;
      end else if (timeout) begin
         sh_d = level;
         sl_d = ~level;
      end

      if (timeout) begin
         state_d = ST_SYNC;
      end else begin
         case (state_q)
            ST_SYNC: begin
               if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
               if (fall) begin
                  state_d = ST_LOW;
                  pend_d  = cnt_q;
               end
            end
            ST_LOW: begin
               if (rise) begin
                  state_d = ST_HIGH;
                  // a period of exactly TIMEOUT is out of range and not reported
                  if (cnt_q < TMO) begin
                     valid_d = 1'b1;
                     per_d   = cnt_q;
                     high_d  = pend_q;
                  end
               end
            end
            default: state_d = ST_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_SYNC;
         cnt_q   <= '0;
         pend_q  <= '0;
         high_q  <= '0;
         per_q   <= '0;
         valid_q <= 1'b0;
         sh_q    <= 1'b0;
         sl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         high_q  <= high_d;
         per_q   <= per_d;
         valid_q <= valid_d;
         sh_q    <= sh_d;
         sl_q    <= sl_d;
      end
   end

   assign high_time  = high_q;
   assign period     = per_q;
   assign valid      = valid_q;
   assign stuck_high = sh_q;
   assign stuck_low  = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

   localparam int CNT_W = 10;
   localparam int TMO   = 1000;
   localparam int PW    = 257;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] high_time, period;
   logic             valid, stuck_high, stuck_low;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .high_time  (high_time),
      .period     (period),
      .valid      (valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model: synchronized-level history plus event timestamps
   bit ms1, ms2, ms3;
   int now_c = 0, ref_t = 0, last_rise = 0, fall_t = 0;
   bit have_rise = 0, have_fall = 0;
   bit e_valid = 0, e_sh = 0, e_sl = 0;
   int e_ht = 0, e_per = 0;
   bit mon_on = 0;

   int mon_valids = 0;
   bit lit_en = 0;
   int lit_skip = 0, lit_ht = 0, lit_per = 0;
   int gcnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit p);
      int  age;
      bit  rs, fl;
      if (r) begin
         ms1 = 0; ms2 = 0; ms3 = 0;
         have_rise = 0; have_fall = 0;
         ref_t = now_c + 1;
         e_valid = 0; e_sh = 0; e_sl = 0; e_ht = 0; e_per = 0;
         mon_on = 1;
      end else begin
         rs  = ms2 && !ms3;
         fl  = !ms2 && ms3;
         age = now_c - ref_t;
         if (age > TMO) age = TMO;
         e_valid = 0;
         if (rs) begin
            if (have_rise && have_fall && (now_c - last_rise) < TMO) begin
               e_valid = 1;
               e_per   = now_c - last_rise;
               e_ht    = fall_t - last_rise;
            end
            last_rise = now_c; have_rise = 1; have_fall = 0; ref_t = now_c;
         end
         if (fl && have_rise && !have_fall) begin
            fall_t = now_c; have_fall = 1;
         end
         if (rs || fl) begin
            e_sh = 0; e_sl = 0;
         end else if (age == TMO) begin
            e_sh = ms2; e_sl = !ms2;
         end
         ms3 = ms2; ms2 = ms1; ms1 = p;
      end
      now_c++;
   endtask

   task automatic compare();
      logic [CNT_W-1:0] xh, xp;
      if (!mon_on) return;
      xh = e_ht[CNT_W-1:0];
      xp = e_per[CNT_W-1:0];
      tests++;
      if (valid !== e_valid || high_time !== xh || period !== xp ||
          stuck_high !== e_sh || stuck_low !== e_sl) begin
         fails++;
         $display("FAIL model_cmp cycle %0d: dut v=%0b ht=%0d per=%0d sh=%0b sl=%0b, model v=%0b ht=%0d per=%0d sh=%0b sl=%0b",
                  now_c, valid, high_time, period, stuck_high, stuck_low,
                  e_valid, xh, xp, e_sh, e_sl);
      end
      tests++;
      if (stuck_high === 1'b1 && stuck_low === 1'b1) begin
         fails++;
         $display("FAIL both_stuck: got sh=1 sl=1 expected at most one set");
      end
      if (valid === 1'b1) begin
         mon_valids++;
         if (lit_en && mon_valids > lit_skip) begin
            chk("lit_high_time", high_time, lit_ht);
            chk("lit_period", period, lit_per);
         end
      end
   endtask

   task automatic tick(input bit r, input bit p);
      @(negedge clk);
      compare();
      rst    = r;
      pwm_in = p;
      model_step(r, p);
   endtask

   task automatic run_pwm_r(input int duty, input int n, input bit r);
      repeat (n) begin
         tick(r, gcnt < duty);
         gcnt = (gcnt == PW - 1) ? 0 : gcnt + 1;
      end
   endtask

   task automatic run_pwm(input int duty, input int n);
      run_pwm_r(duty, n, 1'b0);
   endtask

   task automatic drive(input bit v, input int n);
      repeat (n) tick(1'b0, v);
   endtask

   task automatic phase(input int duty, input int n, input int skip, input bit lit, input int lht);
      gcnt = 0; mon_valids = 0;
      lit_en = lit; lit_skip = skip; lit_ht = lht; lit_per = PW;
      run_pwm(duty, n);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_high_time"}, high_time, 0);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_stuck_high"}, stuck_high, 0);
      chk({tag, "_stuck_low"}, stuck_low, 0);
   endtask

   initial begin
      repeat (3) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk_zero("reset");

      phase(128, PW * 6, 1, 1, 128);
      chk("n_valid_d128", mon_valids >= 4, 1);
      phase(1, PW * 5, 1, 1, 1);
      chk("n_valid_d1", mon_valids >= 4, 1);
      phase(256, PW * 5, 1, 1, 256);
      chk("n_valid_d256", mon_valids >= 4, 1);

      phase(0, 1300, 0, 0, 0);
      chk("d0_no_valid", mon_valids, 0);
      chk("d0_stuck_low", stuck_low, 1);
      chk("d0_stuck_high", stuck_high, 0);

      phase(64, 4, 0, 1, 64);
      chk("d64_stuck_low_clear", stuck_low, 0);
      run_pwm(64, PW * 3 - 4);
      chk("n_valid_d64", mon_valids >= 2, 1);

      phase(257, 300, 0, 0, 0);
      mon_valids = 0;
      run_pwm(257, 1200);
      chk("d257_no_valid", mon_valids, 0);
      chk("d257_stuck_high", stuck_high, 1);
      chk("d257_stuck_low", stuck_low, 0);

      phase(100, PW * 2 + 50, 0, 0, 0);
      run_pwm_r(100, 1, 1'b1);
      run_pwm(100, 1);
      chk_zero("midrst");
      mon_valids = 0;
      run_pwm(100, PW - gcnt);
      chk("midrst_no_valid", mon_valids, 0);
      lit_en = 1; lit_skip = 1; lit_ht = 100; lit_per = PW;
      run_pwm(100, PW * 2 + 5);
      chk("midrst_n_valid", mon_valids, 3);

      lit_en = 0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      drive(0, 5);
      drive(1, 10);
      drive(0, 990);
      mon_valids = 0;
      drive(1, 6);
      chk("coinc_stuck_high", stuck_high, 0);
      chk("coinc_stuck_low", stuck_low, 0);
      chk("coinc_no_valid", mon_valids, 0);
      lit_en = 1; lit_skip = 0; lit_ht = 50; lit_per = 250;
      drive(1, 44);
      drive(0, 200);
      drive(1, 30);
      drive(0, 20);
      chk("coinc_n_valid", mon_valids, 1);

      lit_en = 0;
      for (int it = 0; it < 14; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               run_pwm_r(0, 1, 1'b1);
               phase($urandom_range(0, 257), $urandom_range(200, 1500), 0, 0, 0);
            end
            1: run_pwm($urandom_range(0, 257), $urandom_range(200, 1500));
            2: begin
               lit_en = 0;
               repeat (30) drive(1'($urandom_range(0, 1)), $urandom_range(1, 40));
            end
            default: phase($urandom_range(1, 256), PW * 3, 1, 0, 0);
         endcase
      end
      tick(1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
